// File: rtl/divider_112_56.sv
// Purpose : sequential restoring divider, 2*div_size-bit dividend by div_size-bit divisor.
// Latency : div_size cycles from the accepted en edge to done; divide-by-zero and overflow answer in 1 cycle.
// Backpressure: none; en is accepted only while busy is low, and en while busy is dropped without queueing.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   en     start strobe, sampled only while busy=0 (the done cycle included)
//   n      dividend, captured on an accepted en
//   d      divisor, captured on an accepted en
//   q, r   quotient / remainder, held until the next completion or reset
//   busy   high while an iteration is in progress
//   done   one-cycle pulse when q/r/err are valid
//   err    set with done on divide-by-zero or quotient overflow
module divider_112_56 #(
  parameter int div_size = 56
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [2*div_size-1:0]   n,
  input  logic [div_size-1:0]     d,
  output logic [div_size-1:0]     q,
  output logic [div_size-1:0]     r,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int cnt_w = $clog2(div_size + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t              state_q, state_d;
  // The partial remainder is always strictly below the divisor once the
  // overflow check has passed, so its top bit would always be zero and is
  // not stored; the trial value below carries the extra bit instead.
  logic [div_size-1:0] rem_q,  rem_d;
  // Low dividend bits shift out of the top while quotient bits shift in at
  // the bottom; after div_size steps this register holds the quotient.
  logic [div_size-1:0] low_q,  low_d;
  logic [div_size-1:0] div_q,  div_d;
  logic [cnt_w-1:0]    cnt_q,  cnt_d;
  logic [div_size-1:0] q_q,    q_d;
  logic [div_size-1:0] r_q,    r_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q,  err_d;

  logic [div_size-1:0] n_hi;
  logic [div_size-1:0] n_lo;
  logic [div_size:0]   trial;
  logic                trial_ge;
  logic [div_size-1:0] trial_sub;

  always_comb begin
    n_hi = n[2*div_size-1:div_size];
    n_lo = n[div_size-1:0];

    // Bring down the next dividend bit next to the partial remainder.
    trial    = {rem_q, low_q[div_size-1]};
    trial_ge = (trial >= {1'b0, div_q});
    // When trial >= divisor the difference is below the divisor, so the
    // low div_size bits of the subtraction are the exact result.
    trial_sub = trial[div_size-1:0] - div_q;

    state_d = state_q;
    rem_d   = rem_q;
    low_d   = low_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          err_d = 1'b0;
          div_d = d;
          rem_d = n_hi;
          low_d = n_lo;
          cnt_d = cnt_w'(div_size);
          // A high half >= divisor means the quotient needs more than
          // div_size bits; d==0 falls into the same test and shares the
          // same saturated answer.
          if ((d == '0) || (n_hi >= d)) begin
            q_d    = '1;
            r_d    = n_lo;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = trial_ge ? trial_sub : trial[div_size-1:0];
        low_d = {low_q[div_size-2:0], trial_ge};
        cnt_d = cnt_q - cnt_w'(1);
        // Last iteration: publish the freshly computed bit and remainder.
        if (cnt_q == cnt_w'(1)) begin
          q_d     = low_d;
          r_d     = rem_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      low_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      low_q   <= low_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_divider_112_56.sv
// Purpose : directed + random bench for divider_112_56 with a result scoreboard.
// Latency : expects done div_size edges after the accepting edge, or on that edge for errors.
// Backpressure: exercises en while busy (ignored), en in the done cycle, and reset mid-operation.
module tb_divider_112_56;
  localparam int W = 56;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [2*W-1:0] n = '0;
  logic [W-1:0]   d = '0;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           busy;
  logic           done;
  logic           err;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  divider_112_56 #(.div_size(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .n    (n),
    .d    (d),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];

  // Reference: plain wide division, saturating on d==0 or quotient overflow.
  function automatic exp_t model(input logic [2*W-1:0] nv, input logic [W-1:0] dv);
    exp_t e;
    logic [2*W-1:0] dw;
    dw = {{W{1'b0}}, dv};
    if ((dv == '0) || (nv[2*W-1:W] >= dv)) begin
      e.q = '1;
      e.r = nv[W-1:0];
      e.err = 1'b1;
      e.lat = 0;
    end else begin
      e.q = W'(nv / dw);
      e.r = W'(nv % dw);
      e.err = 1'b0;
      e.lat = W;
    end
    return e;
  endfunction

  // Starts at a negedge, ends at the negedge where done is seen. lat counts
  // clock edges after the accepting edge at which done was registered.
  task automatic run_op(input logic [2*W-1:0] nv, input logic [W-1:0] dv, input bit poke);
    exp_t e;
    exp_t got_e;
    int j;
    bit seen;
    logic [2*W-1:0] prod;
    e = model(nv, dv);
    sb.push_back(e);
    n = nv;
    d = dv;
    en = 1'b1;
    seen = 1'b0;
    j = 0;
    while (!seen && j < 200) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        en = 1'b0;
        chk("busy_at_accept", busy, !e.err);
        if (!e.err) chk("err_cleared", err, 1'b0);
      end
      if (poke && (j == 10 || j == 30)) begin
        n = 112'd77;
        d = 56'd2;
        en = 1'b1;
      end else if (poke && (j == 11 || j == 31)) begin
        en = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      got_e = sb.pop_front();
      chk("latency", j - 1, got_e.lat);
      chk("q", q, got_e.q);
      chk("r", r, got_e.r);
      chk("err", err, got_e.err);
      chk("busy_at_done", busy, 1'b0);
      if (!got_e.err) begin
        prod = {{W{1'b0}}, q} * {{W{1'b0}}, dv} + {{W{1'b0}}, r};
        chk("recombine", prod, nv);
        chk("r_lt_d", (r < dv), 1'b1);
      end
    end else begin
      sb.delete(0);
    end
  endtask

  initial begin
    logic [W-1:0]   m;
    logic [2*W-1:0] big;
    logic [W-1:0]   dv;
    logic [W-1:0]   qv;
    logic [W-1:0]   rv;
    logic [2*W-1:0] nv;
    bit             seen;

    repeat (3) @(negedge clk);
    chk("rst_q", q, 56'd0);
    chk("rst_r", r, 56'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide, then a new operation launched in the done cycle.
    run_op(112'd100, 56'd7, 1'b0);
    run_op(112'd81, 56'd9, 1'b0);
    @(negedge clk);
    chk("done_single_pulse", done, 1'b0);

    // Largest non-overflowing operands.
    m = '1;
    big = {{W{1'b0}}, m} * {{W{1'b0}}, m};
    run_op(big, m, 1'b0);
    run_op(big + 112'd5, m, 1'b0);

    // Divide by zero, then overflow, then the just-fitting neighbour.
    run_op(112'h1234, 56'd0, 1'b0);
    run_op(112'd5 << W, 56'd5, 1'b0);
    run_op((112'd5 << W) - 112'd1, 56'd5, 1'b0);

    // en pulses while busy must not disturb the running operation.
    run_op(112'd1000, 56'd3, 1'b1);
    @(negedge clk);
    chk("done_single_pulse_2", done, 1'b0);

    // Reset in the middle of an operation.
    n = 112'd1000;
    d = 56'd3;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (18) @(negedge clk);
    chk("busy_before_abort", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", q, 56'd0);
    chk("abort_r", r, 56'd0);
    chk("abort_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_abort", seen, 1'b0);

    // Random vectors, mostly built as q*d+r so they fit, some raw.
    for (int i = 0; i < 1000; i++) begin
      dv = W'({$urandom, $urandom}) >> $urandom_range(0, W - 1);
      if (i % 50 == 0) dv = '0;
      qv = W'({$urandom, $urandom});
      rv = (dv == '0) ? '0 : (W'({$urandom, $urandom}) % dv);
      nv = {{W{1'b0}}, qv} * {{W{1'b0}}, dv} + {{W{1'b0}}, rv};
      if (i % 8 == 3) nv = (2*W)'({$urandom, $urandom, $urandom, $urandom});
      run_op(nv, dv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_112_56.md
Name: divider_112_56

Overview:
- Sequential restoring divider, the inverse-direction companion to the team's 56x56 pipelined multiplier.
- Takes a 112-bit dividend (typically a multiplier product) and a 56-bit divisor.
- Returns a 56-bit quotient and 56-bit remainder after a fixed number of cycles, one quotient bit per cycle.
- Used for modular reduction and quotient recovery in the datapath downstream of the multiplier.

Parameters:
- div_size, 56, divisor/quotient/remainder width; dividend is 2*div_size bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start strobe; sampled only when busy=0
- n  input  2*div_size  dividend; captured on accepted en
- d  input  div_size  divisor; captured on accepted en
- q  output  div_size  quotient register
- r  output  div_size  remainder register
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when q/r/err are valid
- err  output  1  set with done when d==0 or the quotient overflows; cleared on next accepted en

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, and q, r, busy, done, err, iteration counter and all internal registers are 0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC.
- IDLE, en=1 at edge k (accepted en):
  - clear err.
  - Capture d into divisor register.
  - Partial remainder rem (div_size+1 bits) <= {1'b0, n[2*div_size-1:div_size]}.
  - Low shift register <= n[div_size-1:0].
  - cnt <= div_size.
- Error checks at acceptance:
  - d==0: at edge k, q <= all ones, r <= n[div_size-1:0], err <= 1, done <= 1. Stay IDLE. Divide-by-zero takes priority over overflow.
  - n[2*div_size-1:div_size] >= d (quotient does not fit): same response, except q <= all ones and r <= n[div_size-1:0].
  - Otherwise busy <= 1 and the block enters CALC.
- CALC, each edge:
  - t = {rem[div_size-1:0], msb of low shift register} (div_size+1 bits).
  - If t >= {1'b0, d}: rem <= t - d and shift in quotient bit 1; else rem <= t and shift in 0.
  - Shift the low register left by 1; cnt <= cnt-1.
- Completion: on the edge where cnt reaches 0 (edge k+div_size):
  - q <= quotient shift register, r <= rem[div_size-1:0].
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle following edge k+div_size, i.e. 56 cycles after the en edge; the error path takes 1 cycle.
- done is a single-cycle pulse and deasserts on the following edge unless a new completion occurs.
- en with busy=1 is ignored; no queueing, and captured operands are unaffected.
- en in the cycle where done=1 (state IDLE) is accepted: back-to-back throughput is one result per 57 cycles.
- q, r and err hold their values until the next completion or reset.
- Invariant on non-error results: n == q*d + r and r < d.
- All comparisons and subtractions are unsigned.

Test Plan:
- n=100, d=7, en pulse -> busy for 56 cycles, done 56 cycles after en; q=14, r=2, err=0.
- n=(2^56-1)^2, d=2^56-1 -> q=2^56-1, r=0, err=0; repeat with n=(2^56-1)^2+5 -> q=2^56-1, r=5.
- d=0, n=0x1234 -> done 1 cycle after en; err=1, q=0xFFFFFFFFFFFFFF, r=0x1234, busy never high.
- n=5*2^56, d=5 (overflow) -> done after 1 cycle, err=1, q=all ones; then n=5*2^56-1, d=5 -> err=0, q=2^56-1, r=4.
- en re-asserted at cycles 10 and 30 of a busy operation (n=1000, d=3) -> ignored, result q=333, r=1. Separately, rst_n=0 at cycle 20 -> busy, done, q, r, err immediately 0 and no done follows.
- en asserted in the done cycle with new operands (n=81, d=9) -> accepted; second done 56 cycles later, q=9, r=0. Random 1000-vector check of n==q*d+r against a reference model.
